// File: rtl/imem_loader.sv
// Instruction-memory loader: collects a little-endian byte stream into 32-bit words,
// writes them to IMEM from address 0 and holds the core in reset while loading.
module imem_loader #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic              clk,
    input  logic              Reset_n,
    input  logic              start,
    input  logic [8:0]        word_count,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [7:0]        in_byte,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wd,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int unsigned WC_W = 9;
    localparam logic [WC_W-1:0] MAX_WC = WC_W'(MAX_WORDS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      byte_idx_q;
    logic [WC_W-1:0] words_left_q;
    logic            cpu_hold_q;
    logic            start_ok_c, start_bad_c, abort_c, accept_c, advance_c;

    // Next-state and per-cycle strobes; abort outranks every other transition.
    always_comb begin
        state_d     = state_q;
        start_ok_c  = 1'b0;
        start_bad_c = 1'b0;
        abort_c     = 1'b0;
        accept_c    = 1'b0;
        advance_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if ((word_count != '0) && (word_count <= MAX_WC)) begin
                        start_ok_c = 1'b1;
                        state_d    = COLLECT;
                    end else begin
                        start_bad_c = 1'b1;
                    end
                end
            end
            COLLECT: begin
                if (abort) begin
                    abort_c = 1'b1;
                    state_d = IDLE;
                end else if (in_valid && in_ready) begin
                    accept_c = 1'b1;
                    if (byte_idx_q == 2'd3) begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                if (abort) begin
                    abort_c = 1'b1;
                    state_d = IDLE;
                end else begin
                    advance_c = 1'b1;
                    state_d   = (words_left_q == WC_W'(1)) ? RELEASE : COLLECT;
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!Reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk) begin
        if (!Reset_n) begin
            in_ready     <= 1'b0;
            imem_we      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            imem_addr    <= '0;
            imem_wd      <= '0;
            byte_idx_q   <= '0;
            words_left_q <= '0;
            cpu_hold_q   <= 1'b0;
        end else begin
            in_ready <= (state_d == COLLECT);
            imem_we  <= (state_d == WRITE);
            busy     <= (state_d != IDLE);
            done     <= (state_d == RELEASE);
            error    <= start_bad_c | abort_c;

            if (start_ok_c) begin
                imem_addr    <= '0;
                byte_idx_q   <= '0;
                words_left_q <= word_count;
                cpu_hold_q   <= 1'b1;
            end
            if (accept_c) begin
                imem_wd[{byte_idx_q, 3'b000} +: 8] <= in_byte;
                byte_idx_q                         <= byte_idx_q + 2'd1;
            end
            if (abort_c) begin
                byte_idx_q <= '0;
            end
            if (advance_c) begin
                imem_addr    <= imem_addr + ADDR_W'(4);
                words_left_q <= words_left_q - WC_W'(1);
            end
            if (state_q == RELEASE) begin
                cpu_hold_q <= 1'b0;
            end
        end
    end

    assign cpu_reset = cpu_hold_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: randomized byte streams against a queue-based
// model of the expected IMEM writes, plus the directed boundary scenarios.
module tb_imem_loader;

    localparam int unsigned ADDR_W    = 10;
    localparam int unsigned MAX_WORDS = 256;

    logic              clk = 1'b0;
    logic              Reset_n;
    logic              start;
    logic [8:0]        word_count;
    logic              abort;
    logic              in_valid;
    logic [7:0]        in_byte;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wd;
    logic              cpu_reset;
    logic              busy;
    logic              done;
    logic              error;

    imem_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
        .clk(clk), .Reset_n(Reset_n), .start(start), .word_count(word_count),
        .abort(abort), .in_valid(in_valid), .in_byte(in_byte), .in_ready(in_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wd(imem_wd),
        .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [31:0]       d;
    } wr_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          err_cnt = 0;
    int          done_cnt = 0;
    wr_t         wr_q[$];
    wr_t         exp_q[$];
    logic [7:0]  bq[$];
    int          pat[$];

    always @(posedge clk) cyc++;

    // Observe DUT activity mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (imem_we === 1'b1) wr_q.push_back({imem_addr, imem_wd});
        if (error === 1'b1) err_cnt++;
        if (done === 1'b1) done_cnt++;
    end

    // Reference: the first nbytes of bq, grouped in fours, little-endian, at 4*k.
    task automatic model_load(input int nbytes);
        exp_q.delete();
        for (int k = 0; k < nbytes / 4; k++) begin
            exp_q.push_back({ADDR_W'(4 * k), bq[4*k+3], bq[4*k+2], bq[4*k+1], bq[4*k]});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [8:0] n);
        start = 1'b1;
        word_count = n;
        tick();
        start = 1'b0;
        word_count = 9'($urandom);
    endtask

    // Offer bq[0..nbytes-1] in order, each held until the handshake takes it.
    task automatic send(input int nbytes, input int vprob, input bit stray, output int first_cyc);
        int i = 0;
        int k = 0;
        int g = 0;
        bit hs;
        first_cyc = -1;
        while (i < nbytes && g < 20000) begin
            if (pat.size() > 0) in_valid = (k < pat.size()) ? (pat[k] != 0) : 1'b1;
            else in_valid = ($urandom_range(99) < 32'(vprob));
            in_byte = bq[i];
            if (stray) begin
                start = ($urandom_range(3) == 0);
                word_count = 9'($urandom);
            end
            @(negedge clk);
            hs = in_valid && in_ready;
            if (hs && first_cyc < 0) first_cyc = cyc;
            @(posedge clk);
            #1;
            if (hs) i++;
            k++;
            g++;
        end
        in_valid = 1'b0;
        start = 1'b0;
        n_cmp++;
        if (i != nbytes) begin
            n_bad++;
            $display("FAIL send_timeout: accepted %0d bytes, expected %0d", i, nbytes);
        end
    endtask

    task automatic wait_done(input int budget, output int dcyc, output logic cr);
        int k = 0;
        dcyc = -1;
        cr = 1'bx;
        while (k < budget) begin
            @(negedge clk);
            if (done === 1'b1) begin
                dcyc = cyc;
                cr = cpu_reset;
                break;
            end
            k++;
        end
        tick();
        n_cmp++;
        if (dcyc < 0) begin
            n_bad++;
            $display("FAIL done_timeout: no done within %0d cycles", budget);
        end
    endtask

    task automatic test_reset();
        Reset_n = 1'b0; start = 1'b0; word_count = '0; abort = 1'b0;
        in_valid = 1'b0; in_byte = '0;
        repeat (3) tick();
        n_cmp++;
        if ({in_ready, imem_we, imem_addr, imem_wd, cpu_reset, busy, done, error} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got we=%b rdy=%b addr=%h wd=%h cr=%b busy=%b done=%b err=%b, expected all 0",
                     imem_we, in_ready, imem_addr, imem_wd, cpu_reset, busy, done, error);
        end
        Reset_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int e0, d0, fc, dc;
        logic cr;
        bq = {8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        pat.delete();
        wr_q.delete(); e0 = err_cnt; d0 = done_cnt;
        do_start(9'd2);
        n_cmp++;
        if (cpu_reset !== 1'b1 || busy !== 1'b1) begin
            n_bad++; $display("FAIL basic_hold: got cr=%b busy=%b, expected 1 1", cpu_reset, busy);
        end
        send(8, 100, 1'b0, fc);
        wait_done(20, dc, cr);
        n_cmp++;
        if (cr !== 1'b1) begin n_bad++; $display("FAIL basic_cr_release: got %b expected 1", cr); end
        n_cmp++;
        if (cpu_reset !== 1'b0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL basic_after: got cr=%b busy=%b, expected 0 0", cpu_reset, busy);
        end
        n_cmp++;
        if (wr_q.size() != 2 || wr_q[0] !== {ADDR_W'(0), 32'h00500013} || wr_q[1] !== {ADDR_W'(4), 32'h00100093}) begin
            n_bad++; $display("FAIL basic_writes: got %0d writes, first %h, expected 2 writes 000/00500013 004/00100093",
                              wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : '0);
        end
        n_cmp++;
        if (done_cnt - d0 != 1 || err_cnt - e0 != 0) begin
            n_bad++; $display("FAIL basic_pulses: got done=%0d err=%0d, expected 1 0", done_cnt - d0, err_cnt - e0);
        end
    endtask

    task automatic test_bad_start();
        logic [8:0] bad [2];
        int e0;
        logic b1;
        bad[0] = 9'd0;
        bad[1] = 9'd257;
        for (int j = 0; j < 2; j++) begin
            wr_q.delete(); e0 = err_cnt;
            do_start(bad[j]);
            b1 = busy;
            repeat (3) tick();
            n_cmp++;
            if (err_cnt - e0 != 1 || b1 !== 1'b0 || busy !== 1'b0 || wr_q.size() != 0) begin
                n_bad++; $display("FAIL bad_start_%0d: got err=%0d busy=%b/%b writes=%0d, expected 1 0/0 0",
                                  bad[j], err_cnt - e0, b1, busy, wr_q.size());
            end
        end
    endtask

    task automatic test_stall();
        int fc, dc;
        logic cr;
        bq = {8'hEF, 8'hBE, 8'hAD, 8'hDE};
        pat = {1, 0, 0, 1, 1, 0, 1};
        wr_q.delete();
        do_start(9'd1);
        send(4, 100, 1'b0, fc);
        pat.delete();
        wait_done(20, dc, cr);
        n_cmp++;
        if (wr_q.size() != 1 || wr_q[0] !== {ADDR_W'(0), 32'hDEADBEEF}) begin
            n_bad++; $display("FAIL stall_write: got %0d writes first %h, expected 1 write 000/deadbeef",
                              wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : '0);
        end
    endtask

    task automatic test_random();
        int n, fc, dc, d0, e0;
        logic cr;
        pat.delete();
        for (int it = 0; it < 8; it++) begin
            n = $urandom_range(1, 6);
            bq.delete();
            for (int b = 0; b < 4 * n; b++) bq.push_back(8'($urandom));
            model_load(4 * n);
            wr_q.delete(); d0 = done_cnt; e0 = err_cnt;
            do_start(9'(n));
            send(4 * n, $urandom_range(30, 100), 1'b1, fc);
            wait_done(20, dc, cr);
            n_cmp++;
            if (wr_q.size() != exp_q.size()) begin
                n_bad++; $display("FAIL rand%0d_count: got %0d writes, expected %0d", it, wr_q.size(), exp_q.size());
            end else begin
                for (int k = 0; k < exp_q.size(); k++) begin
                    n_cmp++;
                    if (wr_q[k] !== exp_q[k]) begin
                        n_bad++; $display("FAIL rand%0d_write%0d: got %h expected %h", it, k, wr_q[k], exp_q[k]);
                    end
                end
            end
            n_cmp++;
            if (done_cnt - d0 != 1 || err_cnt - e0 != 0 || cpu_reset !== 1'b0) begin
                n_bad++; $display("FAIL rand%0d_end: got done=%0d err=%0d cr=%b, expected 1 0 0",
                                  it, done_cnt - d0, err_cnt - e0, cpu_reset);
            end
        end
    endtask

    task automatic test_full();
        int fc, dc;
        logic cr;
        int bad_w = 0;
        pat.delete();
        bq.delete();
        for (int b = 0; b < 4 * int'(MAX_WORDS); b++) bq.push_back(8'($urandom));
        model_load(4 * int'(MAX_WORDS));
        wr_q.delete();
        do_start(9'(MAX_WORDS));
        send(4 * int'(MAX_WORDS), 100, 1'b0, fc);
        wait_done(20, dc, cr);
        n_cmp++;
        if (dc - fc + 1 != 5 * int'(MAX_WORDS) + 1) begin
            n_bad++; $display("FAIL full_latency: got %0d cycles, expected %0d", dc - fc + 1, 5 * int'(MAX_WORDS) + 1);
        end
        n_cmp++;
        if (wr_q.size() != int'(MAX_WORDS) || wr_q[wr_q.size()-1].a !== ADDR_W'(10'h3FC)) begin
            n_bad++; $display("FAIL full_count: got %0d writes, expected %0d ending at 3fc", wr_q.size(), MAX_WORDS);
        end else begin
            for (int k = 0; k < exp_q.size(); k++) if (wr_q[k] !== exp_q[k]) bad_w++;
            n_cmp++;
            if (bad_w != 0) begin
                n_bad++; $display("FAIL full_data: got %0d wrong writes, expected 0", bad_w);
            end
        end
    endtask

    task automatic test_abort();
        int fc, dc, e0, d0;
        logic cr;
        pat.delete();
        bq.delete();
        for (int b = 0; b < 12; b++) bq.push_back(8'($urandom));
        model_load(4);
        wr_q.delete(); e0 = err_cnt; d0 = done_cnt;
        do_start(9'd3);
        send(6, 100, 1'b0, fc);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if (wr_q.size() != 1 || wr_q[0] !== exp_q[0]) begin
            n_bad++; $display("FAIL abort_writes: got %0d writes, expected 1 write %h", wr_q.size(), exp_q[0]);
        end
        n_cmp++;
        if (err_cnt - e0 != 1 || done_cnt - d0 != 0 || busy !== 1'b0 || cpu_reset !== 1'b1) begin
            n_bad++; $display("FAIL abort_state: got err=%0d done=%0d busy=%b cr=%b, expected 1 0 0 1",
                              err_cnt - e0, done_cnt - d0, busy, cpu_reset);
        end
        bq.delete();
        for (int b = 0; b < 4; b++) bq.push_back(8'($urandom));
        model_load(4);
        wr_q.delete();
        do_start(9'd1);
        send(4, 70, 1'b0, fc);
        wait_done(20, dc, cr);
        n_cmp++;
        if (cpu_reset !== 1'b0 || wr_q.size() != 1 || wr_q[0] !== exp_q[0]) begin
            n_bad++; $display("FAIL abort_reload: got cr=%b writes=%0d, expected 0 and 1 write %h",
                              cpu_reset, wr_q.size(), exp_q[0]);
        end
    endtask

    task automatic test_abort_write();
        int fc, e0, d0;
        pat.delete();
        bq.delete();
        for (int b = 0; b < 4; b++) bq.push_back(8'($urandom));
        model_load(4);
        wr_q.delete(); e0 = err_cnt; d0 = done_cnt;
        do_start(9'd1);
        send(4, 100, 1'b0, fc);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if (wr_q.size() != 1 || wr_q[0] !== exp_q[0]) begin
            n_bad++; $display("FAIL abortw_write: got %0d writes, expected 1 write %h", wr_q.size(), exp_q[0]);
        end
        n_cmp++;
        if (err_cnt - e0 != 1 || done_cnt - d0 != 0 || busy !== 1'b0 || cpu_reset !== 1'b1) begin
            n_bad++; $display("FAIL abortw_state: got err=%0d done=%0d busy=%b cr=%b, expected 1 0 0 1",
                              err_cnt - e0, done_cnt - d0, busy, cpu_reset);
        end
    endtask

    task automatic test_reset_mid();
        int fc, dc;
        logic cr;
        pat.delete();
        bq.delete();
        for (int b = 0; b < 4; b++) bq.push_back(8'($urandom));
        wr_q.delete();
        do_start(9'd2);
        send(2, 100, 1'b0, fc);
        Reset_n = 1'b0;
        tick();
        n_cmp++;
        if ({in_ready, imem_we, imem_addr, imem_wd, cpu_reset, busy, done, error} !== '0) begin
            n_bad++; $display("FAIL midreset_outputs: got we=%b rdy=%b addr=%h wd=%h cr=%b busy=%b, expected all 0",
                              imem_we, in_ready, imem_addr, imem_wd, cpu_reset, busy);
        end
        Reset_n = 1'b1;
        repeat (2) tick();
        n_cmp++;
        if (wr_q.size() != 0) begin
            n_bad++; $display("FAIL midreset_nowrite: got %0d writes, expected 0", wr_q.size());
        end
        model_load(4);
        do_start(9'd1);
        send(4, 100, 1'b0, fc);
        wait_done(20, dc, cr);
        n_cmp++;
        if (wr_q.size() != 1 || wr_q[0] !== exp_q[0]) begin
            n_bad++; $display("FAIL midreset_reload: got %0d writes, expected 1 write %h", wr_q.size(), exp_q[0]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_start();
        test_stall();
        test_random();
        test_full();
        test_abort();
        test_abort_write();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, byte-address width of instruction memory.
REQ-002 SHALL have parameter MAX_WORDS, default 256, instruction-memory capacity in 32-bit words (2^ADDR_W/4).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port Reset_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle load request, sampled only in IDLE.
REQ-006 SHALL have port word_count  input  9  words to load, sampled with start.
REQ-007 SHALL have port abort  input  1  cancel an in-progress load.
REQ-008 SHALL have port in_valid  input  1  byte-stream data valid.
REQ-009 SHALL have port in_byte  input  8  byte-stream data.
REQ-010 SHALL have port in_ready  output  1  loader accepts in_byte this cycle.
REQ-011 SHALL have port imem_we  output  1  instruction-memory write enable.
REQ-012 SHALL have port imem_addr  output  ADDR_W  instruction-memory byte address.
REQ-013 SHALL have port imem_wd  output  32  instruction-memory write data.
REQ-014 SHALL have port cpu_reset  output  1  active-high hold of the core's Reset.
REQ-015 SHALL have port busy  output  1  high in any state except IDLE.
REQ-016 SHALL have port done  output  1  one-cycle pulse on successful completion.
REQ-017 SHALL have port error  output  1  one-cycle pulse on rejected start or abort.

Function
REQ-018 SHALL implement states IDLE, COLLECT, WRITE, RELEASE; all outputs registered or decoded from state only.
REQ-019 IDLE: in_ready=0, imem_we=0; start with 1<=word_count<=MAX_WORDS -> COLLECT, imem_addr<=0, byte index<=0, words_left<=word_count, cpu_hold<=1.
REQ-020 IDLE: start with word_count==0 or >MAX_WORDS -> error pulse next cycle, stay IDLE, cpu_hold unchanged.
REQ-021 start SHALL be ignored in any state other than IDLE.
REQ-022 COLLECT: in_ready=1; a byte is accepted only when in_valid&&in_ready; in_valid low stalls indefinitely with no state change.
REQ-023 Byte assembly little-endian: accepted byte k (0..3) lands in imem_wd[8k+7:8k]; byte index wraps 3->0.
REQ-024 Acceptance of byte 3 -> WRITE on the next cycle.
REQ-025 WRITE: exactly one cycle, imem_we=1, in_ready=0, imem_addr/imem_wd stable and valid that cycle.
REQ-026 Leaving WRITE: imem_addr<=imem_addr+4 (mod 2^ADDR_W), words_left<=words_left-1; if new words_left==0 -> RELEASE, else COLLECT.
REQ-027 RELEASE: one cycle, cpu_reset=1, done pulses high; next cycle IDLE with cpu_hold=0.
REQ-028 cpu_reset SHALL equal cpu_hold; held high from the cycle after an accepted start through RELEASE inclusive.
REQ-029 abort in COLLECT or WRITE -> IDLE next cycle, partial word discarded, no further imem_we, error pulse, cpu_hold stays 1 until a later load completes.
REQ-030 abort with a WRITE cycle: that cycle's write still occurs; abort takes priority over the transition to RELEASE.
REQ-031 abort in IDLE or RELEASE SHALL be ignored.
REQ-032 Throughput: N words with in_valid held high complete in 5N+1 cycles from first accepted byte to done.

Reset
REQ-033 Reset_n low at a rising edge SHALL force IDLE, imem_we=0, in_ready=0, imem_addr=0, imem_wd=0, cpu_hold=0, busy=0, done=0, error=0, byte index=0, words_left=0.
REQ-034 Reset mid-load SHALL discard all progress with no imem_we pulse in or after the reset cycle.

Verification
REQ-035 start, word_count=2, bytes 13,00,50,00,93,00,10,00 back-to-back -> imem_we at addr 0x000 data 0x00500013, addr 0x004 data 0x00100093; done after second write; cpu_reset 1 throughout, 0 after RELEASE.
REQ-036 start, word_count=0 and separately word_count=257 -> single error pulse each, busy stays 0, no imem_we.
REQ-037 word_count=1, in_valid toggled 1-0-0-1-1-0-1 with bytes EF,BE,AD,DE -> one write data 0xDEADBEEF addr 0x000; no byte lost or duplicated.
REQ-038 word_count=256, continuous stream -> 256 writes, last addr 0x3FC, done at cycle 1281 after first byte, no address wrap write.
REQ-039 word_count=3, abort after 6 bytes -> one write only (addr 0x000), error pulse, IDLE, cpu_reset remains 1; subsequent 1-word load -> done, cpu_reset 0.
REQ-040 Reset_n low for one cycle after 2 bytes of a load -> all outputs at reset values, no write; new start loads from addr 0x000.
